// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : SPI mode-0 master; one full-duplex DATA_WIDTH-bit transfer per START.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  slvsel_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int                 c_BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_BITS_ALL = c_BIT_W'(DATA_WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [DIV_WIDTH:0] c_CNT_ONE  = (DIV_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [DIV_WIDTH:0]    cnt_q,     cnt_d;
    logic [DIV_WIDTH:0]    h_q,       h_d;
    logic [c_BIT_W-1:0]    bits_q,    bits_d;
    logic [DATA_WIDTH-1:0] tx_sh_q,   tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  slvsel_q,  slvsel_d;
    logic                  sclk_q,    sclk_d;
    logic                  mosi_q,    mosi_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  w_phase_end;
    logic                  w_tx_first;
    logic                  w_tx_next;
    logic [DATA_WIDTH-1:0] w_tx_load;
    logic [DATA_WIDTH-1:0] w_tx_shift;
    logic [DATA_WIDTH-1:0] w_rx_shift;

    // tx_sh holds only the bits not yet on MOSI; its head is the next bit out.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_tx_first = tx_data_i[0];
            assign w_tx_load  = {1'b0, tx_data_i[DATA_WIDTH-1:1]};
            assign w_tx_next  = tx_sh_q[0];
            assign w_tx_shift = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
            assign w_rx_shift = {miso_i, rx_sh_q[DATA_WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_tx_first = tx_data_i[DATA_WIDTH-1];
            assign w_tx_load  = {tx_data_i[DATA_WIDTH-2:0], 1'b0};
            assign w_tx_next  = tx_sh_q[DATA_WIDTH-1];
            assign w_tx_shift = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            assign w_rx_shift = {rx_sh_q[DATA_WIDTH-2:0], miso_i};
        end
    endgenerate

    // Counter is one bit wider than CLK_DIV so H = CLK_DIV+1 never wraps.
    assign w_phase_end = ((cnt_q + c_CNT_ONE) == h_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        h_d       = h_q;
        bits_d    = bits_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        slvsel_d  = slvsel_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = w_phase_end ? '0 : (cnt_q + c_CNT_ONE);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SETUP;
                    cnt_d    = '0;
                    h_d      = {1'b0, clk_div_i} + c_CNT_ONE;
                    bits_d   = '0;
                    rx_sh_d  = '0;
                    tx_sh_d  = w_tx_load;
                    mosi_d   = w_tx_first;
                    slvsel_d = 1'b0;
                    sclk_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_phase_end) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                    rx_sh_d = w_rx_shift;
                    bits_d  = bits_q + c_BIT_ONE;
                end
            end
            ST_HIGH: begin
                if (w_phase_end) begin
                    state_d = ST_LOW;
                    sclk_d  = 1'b0;
                    // After the last sample MOSI keeps its bit through the hold phase.
                    if (bits_q != c_BITS_ALL) begin
                        mosi_d  = w_tx_next;
                        tx_sh_d = w_tx_shift;
                    end
                end
            end
            ST_LOW: begin
                if (w_phase_end) begin
                    if (bits_q == c_BITS_ALL) begin
                        state_d   = ST_IDLE;
                        slvsel_d  = 1'b1;
                        sclk_d    = 1'b0;
                        mosi_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                    end else begin
                        state_d = ST_HIGH;
                        sclk_d  = 1'b1;
                        rx_sh_d = w_rx_shift;
                        bits_d  = bits_q + c_BIT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            h_q       <= '0;
            bits_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            slvsel_q  <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            h_q       <= h_d;
            bits_q    <= bits_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            slvsel_q  <= slvsel_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign slvsel_o  = slvsel_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Synthesizable SPI mode-0 master (CPOL=0, CPHA=0) that drives the SLVSEL/SCLK/MOSI lines and samples MISO, directly upstream of the SPI bus interface.
- A single-cycle START launches one full-duplex transfer of DATA_WIDTH bits.
- SCLK is derived from CLK by a programmable divider, so the interface's SCLK period/frequency monitor has a deterministic value to check.
- Sits between a register/command front end and the SPI pins.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
DIV_WIDTH, 8, width of CLK_DIV input
LSB_FIRST, 0, 0 = MSB shifted first on MOSI and into RX_DATA; 1 = LSB first

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  one-cycle transfer request; honoured only when BUSY=0
TX_DATA  input  DATA_WIDTH  word to transmit; latched on accepted START
CLK_DIV  input  DIV_WIDTH  SCLK half-period = CLK_DIV+1 CLK cycles; latched on accepted START
BUSY  output  1  high from cycle after accepted START until DONE cycle (exclusive)
DONE  output  1  one-cycle pulse at end of transfer
RX_DATA  output  DATA_WIDTH  received word; updated only in DONE cycle, held otherwise
SLVSEL  output  1  slave select, active-low
SCLK  output  1  serial clock, idles low
MOSI  output  1  serial data out, idles low
MISO  input  1  serial data in

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values: SLVSEL=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0. State=IDLE; counters and shift registers cleared.
- Reset mid-transfer: the next edge forces reset values. No DONE is produced. RX_DATA is cleared.
- All outputs are registered. H = latched CLK_DIV+1; a CLK_DIV change during a transfer has no effect.
- States and transitions:
  - IDLE: START=1 -> SETUP. On that edge: SLVSEL=0, BUSY=1, MOSI=first bit of TX_DATA.
  - SETUP: H cycles with SCLK=0 -> HIGH.
  - HIGH: entry edge sets SCLK=1 and shifts MISO into the RX shift register. Lasts H cycles -> LOW.
  - LOW: entry edge sets SCLK=0. If bits remain, MOSI = next bit on that same edge. H cycles, then -> HIGH, or -> HOLD if DATA_WIDTH bits have been sampled.
    - Note: the final LOW phase itself is the hold phase. MOSI keeps the last bit through it.
  - HOLD/DONE: exit edge of final LOW sets SLVSEL=1, SCLK=0, MOSI=0, DONE=1, BUSY=0, RX_DATA=shift register -> IDLE.
- Timing:
  - START accepted at edge 0. DONE is high in cycle (2*DATA_WIDTH+1)*H+1.
  - SCLK period = 2H CLK cycles, 50% duty.
  - Exactly DATA_WIDTH SCLK rising edges per transfer, all while SLVSEL=0.
- START handling:
  - START while BUSY=1 is ignored. No queuing.
  - START in the DONE cycle is accepted: SLVSEL high for exactly one cycle, then the new transfer begins.
- Bit order:
  - LSB_FIRST=0: TX_DATA[DATA_WIDTH-1] first; received bits shift in at bit 0 and move toward the MSB.
  - LSB_FIRST=1: mirrored.
- CLK_DIV at maximum (all ones) must not overflow the half-period counter; the counter is DIV_WIDTH+1 bits or equivalent.

Test Plan:
1. Assert RST 3 cycles mid-idle and again at bit 3 of a transfer -> next cycle SLVSEL=1, SCLK=0, MOSI=0, BUSY=0, RX_DATA=0, no DONE pulse.
2. TX_DATA=0xA5, CLK_DIV=1, slave model returning 0x3C on MISO in mode 0:
   - MOSI sequence 1,0,1,0,0,1,0,1 valid at each SCLK rise.
   - 8 SCLK rises; SCLK period 4 CLK (interface sclk_period = 4*Tclk).
   - DONE in cycle 35; RX_DATA=0x3C.
3. CLK_DIV=0, TX_DATA=0xFF, MISO tied 0 -> SCLK period 2 CLK, DONE in cycle 18, RX_DATA=0x00; MOSI=1 from SETUP through the final LOW phase.
4. START pulsed again at cycle 5 of a transfer (TX_DATA=0x11) -> ignored; the transfer completes with the original data and only one DONE.
5. START asserted in the DONE cycle -> SLVSEL high exactly 1 cycle, second transfer completes with its own TX_DATA/RX_DATA; CLK_DIV changed from 1 to 4 mid-first-transfer affects only the second (SCLK period 10 CLK).
6. LSB_FIRST=1 build, TX_DATA=0x01, MISO returns 0x80 -> MOSI first bit 1, then 0s; RX_DATA=0x80.
